// File: rtl/instr_fetch_responder.sv
// Fetch-side program store and PC; answers each fetch edge with one byte.
// Optional FETCH_CNT_EN adds a saturating 16-bit fetch_count output.
module instr_fetch_responder #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              fetch,
  input  logic              finish,
  input  logic              pc_load,
  input  logic [ADDR_W-1:0] pc_in,
  input  logic              prog_we,
  input  logic [ADDR_W-1:0] prog_addr,
  input  logic [DATA_W-1:0] prog_data,
  output logic [DATA_W-1:0] instruction,
  output logic              instr_valid,
  output logic [ADDR_W-1:0] pc_out,
  output logic              busy,
  output logic              halted,
`ifdef FETCH_CNT_EN
  output logic [15:0]       fetch_count,
`endif
  output logic              req_err
);

  typedef enum logic [1:0] {
    LOAD     = 2'd0,
    RUN_IDLE = 2'd1,
    READ     = 2'd2,
    HALT     = 2'd3
  } state_t;

  localparam logic [ADDR_W-1:0] ONE =
    {{(ADDR_W-1){1'b0}}, 1'b1};

  state_t            r_state;
  state_t            w_state_nxt;
  logic [ADDR_W-1:0] r_pc;
  logic [ADDR_W-1:0] w_pc_nxt;
  logic [ADDR_W-1:0] r_addr;
  logic [ADDR_W-1:0] w_addr_nxt;
  logic [DATA_W-1:0] r_instr;
  logic              r_valid;
  logic              r_fetch_q;
  logic              r_req_err;
  logic              w_err_nxt;
  logic              w_we;
  logic              w_req;
  logic              w_start_ok;

  logic [DATA_W-1:0] r_mem [2**ADDR_W];

  assign w_req = fetch & ~r_fetch_q;

  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_addr_nxt  = r_addr;
    w_err_nxt   = r_req_err;
    w_we        = 1'b0;
    w_start_ok  = 1'b0;
    unique case (r_state)
      LOAD: begin
        w_we = prog_we;
        if (w_req) w_err_nxt = 1'b1;
        if (start) begin
          w_start_ok  = 1'b1;
          w_state_nxt = RUN_IDLE;
          w_pc_nxt    = '0;
        end
      end
      RUN_IDLE: begin
        if (pc_load) w_pc_nxt = pc_in;
        if (w_req) begin
          w_state_nxt = READ;
          w_addr_nxt  = pc_load ? pc_in : r_pc;
        end else if (finish) begin
          w_state_nxt = HALT;
        end
      end
      READ: begin
        w_pc_nxt    = r_addr + ONE;
        w_state_nxt = finish ? HALT : RUN_IDLE;
      end
      HALT: begin
        if (w_req) w_err_nxt = 1'b1;
        if (start) begin
          w_start_ok  = 1'b1;
          w_state_nxt = RUN_IDLE;
          w_pc_nxt    = '0;
        end
      end
      default: w_state_nxt = LOAD;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= LOAD;
      r_pc      <= '0;
      r_addr    <= '0;
      r_instr   <= '0;
      r_valid   <= 1'b0;
      r_fetch_q <= 1'b0;
      r_req_err <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_pc      <= w_pc_nxt;
      r_addr    <= w_addr_nxt;
      r_fetch_q <= fetch;
      r_req_err <= w_err_nxt;
      r_valid   <= (r_state == READ);
      if (r_state == READ) r_instr <= r_mem[r_addr];
    end
  end

  // Program store is deliberately left unreset.
  always_ff @(posedge clk) begin
    if (w_we) r_mem[prog_addr] <= prog_data;
  end

`ifdef FETCH_CNT_EN
  logic [15:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (w_start_ok) begin
      r_cnt <= '0;
    end else if (r_state == READ && r_cnt != 16'hFFFF) begin
      r_cnt <= r_cnt + 16'd1;
    end
  end

  assign fetch_count = r_cnt;
`endif

  assign instruction = r_instr;
  assign instr_valid = r_valid;
  assign pc_out      = r_pc;
  assign busy        = (r_state == READ);
  assign halted      = (r_state == HALT);
  assign req_err     = r_req_err;

endmodule

// File: tb/tb_instr_fetch_responder.sv
// Scoreboard bench for instr_fetch_responder.
// Expected bytes are queued on each request, popped on instr_valid.
module tb_instr_fetch_responder;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start, fetch, finish, pc_load, prog_we;
  logic [7:0] pc_in, prog_addr, prog_data;
  logic [7:0] instruction, pc_out;
  logic       instr_valid, busy, halted, req_err;
`ifdef FETCH_CNT_EN
  logic [15:0] fetch_count;
`endif

  instr_fetch_responder dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .fetch(fetch), .finish(finish),
    .pc_load(pc_load), .pc_in(pc_in),
    .prog_we(prog_we), .prog_addr(prog_addr),
    .prog_data(prog_data),
    .instruction(instruction),
    .instr_valid(instr_valid),
    .pc_out(pc_out), .busy(busy),
    .halted(halted),
`ifdef FETCH_CNT_EN
    .fetch_count(fetch_count),
`endif
    .req_err(req_err)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int n_valid = 0;
  int n_exp_valid = 0;
  logic [7:0] sb_q[$];
  logic [7:0] mdl_mem [256];
  logic [7:0] mdl_pc;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (rst_n && instr_valid) begin
      n_valid++;
      if (sb_q.size() == 0) begin
        chk("spurious_valid", 32'(instruction), 32'hDEAD);
      end else begin
        chk("instr", 32'(instruction), 32'(sb_q.pop_front()));
      end
    end
  end

  task automatic wr(input logic [7:0] a,
                    input logic [7:0] d);
    prog_we = 1'b1; prog_addr = a; prog_data = d;
    tick;
    prog_we = 1'b0;
    mdl_mem[a] = d;
  endtask

  task automatic fetch_one(input string tag);
    sb_q.push_back(mdl_mem[mdl_pc]);
    n_exp_valid++;
    fetch = 1'b1;
    tick;
    fetch = 1'b0;
    pc_load = 1'b0;
    chk({tag, "_busy"}, 32'(busy), 32'd1);
    chk({tag, "_early"}, 32'(instr_valid), 32'd0);
    tick;
    chk({tag, "_valid"}, 32'(instr_valid), 32'd1);
    mdl_pc = mdl_pc + 8'd1;
    chk({tag, "_pc"}, 32'(pc_out), 32'(mdl_pc));
    tick;
    chk({tag, "_strobe1"}, 32'(instr_valid), 32'd0);
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_instr"}, 32'(instruction), 32'd0);
    chk({tag, "_valid"}, 32'(instr_valid), 32'd0);
    chk({tag, "_pc"}, 32'(pc_out), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_halt"}, 32'(halted), 32'd0);
    chk({tag, "_err"}, 32'(req_err), 32'd0);
  endtask

  initial begin
    int v0;
    rst_n = 1'b0; start = 1'b0; fetch = 1'b0;
    finish = 1'b0; pc_load = 1'b0; prog_we = 1'b0;
    pc_in = '0; prog_addr = '0; prog_data = '0;
    mdl_pc = '0;
    tick; tick;
    chk_reset_outs("rst");
    rst_n = 1'b1;
    tick;

    // fetch while loading: error, no strobe
    fetch = 1'b1; tick; fetch = 1'b0; tick; tick;
    chk("load_req_err", 32'(req_err), 32'd1);
    chk("load_no_valid", 32'(n_valid), 32'd0);

    wr(8'h00, 8'h06);
    wr(8'h01, 8'h07);
    wr(8'h02, 8'h29);
    wr(8'h03, 8'h33);
    wr(8'h10, 8'h19);
    wr(8'hFF, 8'hA5);
    // write and start together: write lands first
    prog_we = 1'b1; prog_addr = 8'h04;
    prog_data = 8'h44; start = 1'b1;
    tick;
    prog_we = 1'b0; start = 1'b0;
    mdl_mem[4] = 8'h44;
    mdl_pc = 8'h00;
    chk("start_pc", 32'(pc_out), 32'd0);
    tick;

    fetch_one("f0");
    fetch_one("f1");
    fetch_one("f2");
    chk("three_pc", 32'(pc_out), 32'd3);

    // held fetch = one request
    v0 = n_valid;
    sb_q.push_back(mdl_mem[mdl_pc]);
    n_exp_valid++;
    fetch = 1'b1;
    repeat (4) tick;
    fetch = 1'b0;
    tick; tick;
    mdl_pc = mdl_pc + 8'd1;
    chk("hold_one_valid", 32'(n_valid - v0), 32'd1);
    chk("hold_pc", 32'(pc_out), 32'd4);

    fetch_one("wr_start");

    // redirect with request in same cycle
    pc_load = 1'b1; pc_in = 8'h10;
    mdl_pc = 8'h10;
    fetch_one("jmp");
    chk("jmp_pc", 32'(pc_out), 32'h11);

    pc_load = 1'b1; pc_in = 8'hFF;
    tick;
    pc_load = 1'b0;
    mdl_pc = 8'hFF;
    chk("load_ff", 32'(pc_out), 32'hFF);
    tick;
    fetch_one("wrap");
    chk("wrap_pc", 32'(pc_out), 32'h00);

    // finish with request: read completes, then halt
    sb_q.push_back(mdl_mem[mdl_pc]);
    n_exp_valid++;
    fetch = 1'b1; finish = 1'b1;
    tick;
    fetch = 1'b0;
    chk("fin_busy", 32'(busy), 32'd1);
    chk("fin_not_halt", 32'(halted), 32'd0);
    tick;
    finish = 1'b0;
    chk("fin_valid", 32'(instr_valid), 32'd1);
    chk("fin_halt", 32'(halted), 32'd1);
    tick;

    // fetch in halt is refused
    v0 = n_valid;
    fetch = 1'b1; tick; fetch = 1'b0; tick; tick;
    chk("halt_no_valid", 32'(n_valid - v0), 32'd0);
    chk("halt_stay", 32'(halted), 32'd1);
    chk("err_sticky", 32'(req_err), 32'd1);

    // reset in the middle of a read
    start = 1'b1; tick; start = 1'b0;
    chk("restart_pc", 32'(pc_out), 32'd0);
    chk("restart_halt", 32'(halted), 32'd0);
    tick;
    v0 = n_valid;
    fetch = 1'b1; tick; fetch = 1'b0;
    chk("abort_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    chk_reset_outs("abort");
    tick; tick;
    chk("abort_no_valid", 32'(n_valid - v0), 32'd0);
    rst_n = 1'b1;
    tick;

    // fetch in halt from a clean error flag
    start = 1'b1; tick; start = 1'b0;
    finish = 1'b1; tick; finish = 1'b0;
    chk("halt2", 32'(halted), 32'd1);
    chk("halt2_err0", 32'(req_err), 32'd0);
    fetch = 1'b1; tick; fetch = 1'b0; tick;
    chk("halt2_err", 32'(req_err), 32'd1);
    chk("halt2_no_valid", 32'(n_valid - v0), 32'd0);

`ifdef FETCH_CNT_EN
    start = 1'b1; tick; start = 1'b0;
    mdl_pc = 8'h00;
    chk("cnt_zero", 32'(fetch_count), 32'd0);
    for (int i = 0; i < 5; i++) fetch_one("cnt_f");
    chk("cnt_five", 32'(fetch_count), 32'd5);
    finish = 1'b1; tick; finish = 1'b0;
    start = 1'b1; tick; start = 1'b0;
    chk("cnt_clear", 32'(fetch_count), 32'd0);
`endif

    tick; tick;
    chk("sb_empty", 32'(sb_q.size()), 32'd0);
    chk("valid_total", 32'(n_valid), 32'(n_exp_valid));
    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/instr_fetch_responder.md
Name: instr_fetch_responder

Overview:
- Instruction-memory responder on the far end of the control unit's fetch handshake.
- Holds the program store and the fetch-side program counter.
- Answers each `fetch` request with the next instruction byte on `instruction`, strobed by `instr_valid`.
- Accepts program loading before a run and PC redirects for jumps, and stops serving once `finish` is seen.

Parameters:
- DATA_W, 8, instruction byte width
- ADDR_W, 8, program address width; store depth = 2**ADDR_W

Ports:
- clk  input  1  system clock, rising-edge
- rst_n  input  1  reset, asynchronous, active-low
- start  input  1  one-cycle pulse; LOAD or HALT -> RUN_IDLE, pc cleared to 0
- fetch  input  1  fetch request level from the control unit
- finish  input  1  program-end indication from the control unit
- pc_load  input  1  redirect PC (jump)
- pc_in  input  ADDR_W  redirect target
- prog_we  input  1  program write strobe (LOAD state only)
- prog_addr  input  ADDR_W  program write address
- prog_data  input  DATA_W  program write data
- instruction  output  DATA_W  last fetched instruction, held until the next fetch
- instr_valid  output  1  one-cycle strobe when `instruction` updates
- pc_out  output  ADDR_W  current fetch PC
- busy  output  1  high in READ
- halted  output  1  high in HALT
- req_err  output  1  sticky; fetch request seen in LOAD or HALT

Behaviour:
Interface:
- One clock domain. Reset is asynchronous and active-low.
- Reset values: state=LOAD; pc, instruction, fetch_q = 0; instr_valid, busy, halted, req_err = 0.
- Program store contents are not reset.

Request detection:
- req = fetch & ~fetch_q, where fetch_q is fetch registered on clk.
- A fetch held high for several cycles counts as one request; a new request needs fetch to drop for at least one cycle.

States:
- LOAD
  - prog_we writes mem[prog_addr] <= prog_data.
  - start -> RUN_IDLE, pc <= 0. If start and prog_we arrive together, the write completes first.
  - req sets req_err.
- RUN_IDLE
  - pc_load: pc <= pc_in.
  - req -> READ, latching the fetch address. The address is pc_in if pc_load is high in the same cycle, otherwise pc.
  - finish (with no req) -> HALT.
  - prog_we ignored.
- READ (exactly one cycle)
  - instruction <= mem[addr]; instr_valid = 1 for one cycle.
  - pc <= addr + 1, wrapping from 2**ADDR_W-1 to 0.
  - Next state: HALT if finish, else RUN_IDLE.
  - pc_load and req in READ are ignored; the control unit never issues them back-to-back.
- HALT
  - halted = 1; fetch is not served; req sets req_err.
  - start -> RUN_IDLE, pc <= 0, halted <= 0.
  - prog_we ignored.

Latency:
- Request sampled at edge k -> instruction/instr_valid updated at edge k+1.
- This lies within the control unit's FETCH2->FETCH3 window.

Other rules:
- Simultaneous finish and req in RUN_IDLE: req wins; READ completes, then HALT.
- rst_n low mid-READ: aborts immediately to reset values; no instr_valid is emitted.
- pc_out mirrors pc combinationally from the register; busy = (state==READ).

Optional Feature:
- Macro: FETCH_CNT_EN.
- When defined: adds output port fetch_count (16 bits).
  - Reset 0; increments on every READ.
  - Saturates at 16'hFFFF.
  - Cleared to 0 on start.
- When undefined: the port and counter are absent; all other behaviour is identical.

Test Plan:
- Load mem[0..2] = 8'h06, 8'h07, 8'h29; start; three isolated fetch pulses -> instruction = 06, 07, 29, each with a 1-cycle instr_valid one cycle after the request; pc_out ends at 3.
- Hold fetch high for 4 cycles in RUN_IDLE -> exactly one READ and one instr_valid; pc advances by 1.
- pc_load with pc_in = 8'h10 in the same cycle as a fetch request, mem[0x10] = 8'h19 -> instruction = 8'h19; pc_out = 8'h11.
- pc = 8'hFF, fetch -> instruction = mem[0xFF], pc_out wraps to 8'h00; finish and fetch together -> READ completes, then halted = 1.
- Fetch in LOAD and in HALT -> req_err = 1 and stays set; instr_valid stays 0. Assert rst_n low during READ -> all outputs return to reset values with no valid strobe.
- With FETCH_CNT_EN: 5 fetches -> fetch_count = 5; start -> 0.
